hazard_control_unit: RTL and testbench

Parametrised pipeline hazard controller for the RISC-V core, sitting between the ID/EX pipeline registers and the PC/IF-ID write enables. It detects load-use hazards (with x0 and unused-operand filtering) and holds the front end for a configurable number of stall cycles. It squashes a configurable number of younger stages after a taken jump/branch. It also keeps saturating stall/flush event counters for performance debug.

---
 rtl/hazard_control_unit.sv | 114 +++++++++++
 tb/tb_hazard_control_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Load-use stall / redirect flush controller with saturating event counters.
// Zero-latency: hazard and redirect drive the pipeline enables combinationally in the same cycle.
module hazard_control_unit #(
  parameter int ADDR_W       = 5,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_ex,
  input  logic [ADDR_W-1:0] rd_addr_ex,
  input  logic [ADDR_W-1:0] rs1_addr_id,
  input  logic [ADDR_W-1:0] rs2_addr_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              redirect,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              bubble_id,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, next_state;
  logic [2:0] cnt, next_cnt;
  logic       hazard, stall_cyc, flush_cyc, stall_eff, flush_eff;

  assign hazard = mem_read_ex && (rd_addr_ex != '0) &&
                  ((rs1_used_id && (rd_addr_ex == rs1_addr_id)) ||
                   (rs2_used_id && (rd_addr_ex == rs2_addr_id)));

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall_cyc  = 1'b0;
    flush_cyc  = 1'b0;
    // A redirect wins from every state: the current instruction stream is dead.
    if (redirect) begin
      flush_cyc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = FLUSH;
        next_cnt   = FLUSH_RELOAD;
      end else begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hazard) begin
            stall_cyc = 1'b1;
            if (LOAD_STALL > 1) begin
              next_state = STALL;
              next_cnt   = STALL_RELOAD;
            end
          end
        end
        STALL: begin
          stall_cyc = 1'b1;
          next_cnt  = cnt - 3'd1;
          if (cnt == 3'd1) next_state = IDLE;
        end
        FLUSH: begin
          flush_cyc = 1'b1;
          next_cnt  = cnt - 3'd1;
          if (cnt == 3'd1) next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Reset forces the pipeline to free-run even before the state register settles.
  assign stall_eff   = stall_cyc && !rst;
  assign flush_eff   = flush_cyc && !rst;
  assign pc_write    = !stall_eff;
  assign if_id_write = !stall_eff;
  assign bubble_id   = stall_eff;
  assign flush       = flush_eff;
  assign busy        = (state != IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_eff && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_eff && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: dut_a (LOAD_STALL=1, CNT_W=16) and dut_b (LOAD_STALL=3, CNT_W=4).
module tb_hazard_control_unit;

  logic       clk, rst;
  logic       mem_read_ex, rs1_used_id, rs2_used_id, redirect;
  logic [4:0] rd_addr_ex, rs1_addr_id, rs2_addr_id;

  logic        a_pw, a_ifw, a_bub, a_fl, a_busy;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pw, b_ifw, b_bub, b_fl, b_busy;
  logic [3:0]  b_scnt, b_fcnt;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.ADDR_W(5), .LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .mem_read_ex(mem_read_ex), .rd_addr_ex(rd_addr_ex),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .redirect(redirect),
    .pc_write(a_pw), .if_id_write(a_ifw), .bubble_id(a_bub), .flush(a_fl), .busy(a_busy),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_control_unit #(.ADDR_W(5), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .mem_read_ex(mem_read_ex), .rd_addr_ex(rd_addr_ex),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .redirect(redirect),
    .pc_write(b_pw), .if_id_write(b_ifw), .bubble_id(b_bub), .flush(b_fl), .busy(b_busy),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, rdr;
    logic       pw, bub, fl, bsy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u1, input logic u2, input logic rdr);
    mem_read_ex = mr; rd_addr_ex = rd; rs1_addr_id = r1; rs2_addr_id = r2;
    rs1_used_id = u1; rs2_used_id = u2; redirect = rdr;
  endtask

  // Drive one cycle on dut_b, check mid-cycle, then advance past the edge.
  task automatic cyc_b(input string name, input logic mr, input logic rdr,
                       input logic pw, input logic bub, input logic fl, input logic bsy);
    set_in(mr, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, rdr);
    #4;
    chk({name, ".pc_write"}, 32'(b_pw), 32'(pw));
    chk({name, ".if_id_write"}, 32'(b_ifw), 32'(pw));
    chk({name, ".bubble_id"}, 32'(b_bub), 32'(bub));
    chk({name, ".flush"}, 32'(b_fl), 32'(fl));
    chk({name, ".busy"}, 32'(b_busy), 32'(bsy));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    //           mr    rd     r1     r2     u1    u2    rdr   pw    bub   fl    bsy
    tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd12, 5'd1,  5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 5'd9,  5'd9,  5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #3;
    // Reset forces idle outputs even with hazard and redirect asserted.
    chk("rst.pc_write", 32'(a_pw), 32'd1);
    chk("rst.bubble_id", 32'(a_bub), 32'd0);
    chk("rst.flush", 32'(a_fl), 32'd0);
    chk("rst.busy", 32'(b_busy), 32'd0);
    chk("rst.stall_cnt", 32'(a_scnt), 32'd0);
    chk("rst.flush_cnt", 32'(b_fcnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].mr, tbl[i].rd, tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2, tbl[i].rdr);
      #4;
      chk($sformatf("vec%0d.pc_write", i), 32'(a_pw), 32'(tbl[i].pw));
      chk($sformatf("vec%0d.if_id_write", i), 32'(a_ifw), 32'(tbl[i].pw));
      chk($sformatf("vec%0d.bubble_id", i), 32'(a_bub), 32'(tbl[i].bub));
      chk($sformatf("vec%0d.flush", i), 32'(a_fl), 32'(tbl[i].fl));
      chk($sformatf("vec%0d.busy", i), 32'(a_busy), 32'(tbl[i].bsy));
      @(posedge clk); #1;
      if (i == 0) chk("ls1.stall_cnt_after_one", 32'(a_scnt), 32'd1);
    end
    chk("tbl.stall_cnt", 32'(a_scnt), 32'd4);
    chk("tbl.flush_cnt", 32'(a_fcnt), 32'd2);

    // LOAD_STALL=3 with hazard held: exactly three stall cycles.
    do_reset();
    cyc_b("ls3.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc_b("ls3.c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc_b("ls3.c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc_b("ls3.c4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ls3.stall_cnt", 32'(b_scnt), 32'd3);

    // Redirect pulse, re-redirect in cycle 2 extends the flush to 3 cycles.
    do_reset();
    cyc_b("fl.c1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc_b("fl.c2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc_b("fl.c3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc_b("fl.c4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fl.flush_cnt", 32'(b_fcnt), 32'd3);

    // Redirect in the second stall cycle aborts the stall.
    do_reset();
    cyc_b("ab.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc_b("ab.c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc_b("ab.c3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc_b("ab.c4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ab.stall_cnt", 32'(b_scnt), 32'd1);
    chk("ab.flush_cnt", 32'(b_fcnt), 32'd2);

    // 4-bit counter saturates at 15 after 20 stall cycles.
    do_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    chk("sat.stall_cnt", 32'(b_scnt), 32'd15);
    #4;
    chk("sat.still_stalling", 32'(b_bub), 32'd1);
    @(posedge clk); #1;
    chk("sat.stall_cnt_held", 32'(b_scnt), 32'd15);

    // Asynchronous reset in the middle of a flush.
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("arst.pre_busy", 32'(b_busy), 32'd1);
    chk("arst.pre_flush", 32'(b_fl), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.flush", 32'(b_fl), 32'd0);
    chk("arst.busy", 32'(b_busy), 32'd0);
    chk("arst.pc_write", 32'(b_pw), 32'd1);
    chk("arst.flush_cnt", 32'(b_fcnt), 32'd0);
    chk("arst.stall_cnt", 32'(b_scnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    chk("arst.idle_after", 32'(b_fl), 32'd0);
    chk("arst.flush_cnt_after", 32'(b_fcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
